// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - Shared types and constants for the IM/DM SRAM port arbiter
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic       PORT_IM  = 1'b0;
    localparam logic       PORT_DM  = 1'b1;
    localparam logic [3:0] WEB_IDLE = 4'hF;
    localparam int         ADDR_LSB = 2;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - Requester handshakes and SRAM pin bundle for sram_port_arbiter
interface sram_port_arbiter_if #(
    parameter int ADDR_W  = 32,
    parameter int SRAM_AW = 14,
    parameter int DATA_W  = 32
);
    localparam int WSTRB_W = DATA_W / 8;

    logic                im_req_valid;
    logic                im_req_ready;
    logic [ADDR_W-1:0]   im_req_addr;
    logic [WSTRB_W-1:0]  im_req_wstrb;
    logic [DATA_W-1:0]   im_req_wdata;
    logic                im_rsp_valid;
    logic [DATA_W-1:0]   im_rsp_rdata;

    logic                dm_req_valid;
    logic                dm_req_ready;
    logic [ADDR_W-1:0]   dm_req_addr;
    logic [WSTRB_W-1:0]  dm_req_wstrb;
    logic [DATA_W-1:0]   dm_req_wdata;
    logic                dm_rsp_valid;
    logic [DATA_W-1:0]   dm_rsp_rdata;

    logic                CS;
    logic                OE;
    logic [WSTRB_W-1:0]  WEB;
    logic [SRAM_AW-1:0]  A;
    logic [DATA_W-1:0]   DI;
    logic [DATA_W-1:0]   DO;

    modport master (
        output im_req_valid, im_req_addr, im_req_wstrb, im_req_wdata,
        input  im_req_ready, im_rsp_valid, im_rsp_rdata,
        output dm_req_valid, dm_req_addr, dm_req_wstrb, dm_req_wdata,
        input  dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
        input  CS, OE, WEB, A, DI,
        output DO
    );

    modport slave (
        input  im_req_valid, im_req_addr, im_req_wstrb, im_req_wdata,
        output im_req_ready, im_rsp_valid, im_rsp_rdata,
        input  dm_req_valid, dm_req_addr, dm_req_wstrb, dm_req_wdata,
        output dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
        output CS, OE, WEB, A, DI,
        input  DO
    );

endinterface

// File: rtl/sram_port_arbiter_rr_arb2.sv
// rtl/sram_port_arbiter_rr_arb2.sv - Two-requester round-robin grant logic
// Purely combinational; the caller holds last_grant and decides when the window is open.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       enable_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (enable_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                // On a tie the port that did not win last time goes first.
                2'b11:   gnt_o = (last_grant_i == PORT_DM) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - Shares one synchronous SRAM between the IM and DM request ports
// Every access takes a CMD cycle on the pins followed by a RESP cycle that doubles as the next grant window.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int SRAM_AW = 14,
    parameter int DATA_W  = 32
) (
    input logic               CK,
    input logic               RST,
    sram_port_arbiter_if.slave bus
);

    localparam int WSTRB_W = DATA_W / 8;

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 port_q, port_d;
    logic                 rd_q, rd_d;
    logic                 cs_q, cs_d;
    logic                 oe_q, oe_d;
    logic [WSTRB_W-1:0]   web_q, web_d;
    logic [SRAM_AW-1:0]   a_q, a_d;
    logic [DATA_W-1:0]    di_q, di_d;

    logic [1:0]           req;
    logic [1:0]           gnt;
    logic                 grant_en;
    logic                 granted;
    logic                 win_port;
    logic [ADDR_W-1:0]    win_addr;
    logic [WSTRB_W-1:0]   win_wstrb;
    logic [DATA_W-1:0]    win_wdata;
    logic                 win_rd;
    logic                 rsp_active;
    logic                 unused_addr_bits;

    // Ready must stay low while reset is held, even though the state already reads IDLE.
    assign req      = {bus.dm_req_valid, bus.im_req_valid};
    assign grant_en = (state_q != CMD) && !RST;

    rr_arb2 u_rr_arb2 (
        .req_i        (req),
        .enable_i     (grant_en),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    assign granted   = |gnt;
    assign win_port  = gnt[PORT_DM];
    assign win_addr  = win_port ? bus.dm_req_addr  : bus.im_req_addr;
    assign win_wstrb = win_port ? bus.dm_req_wstrb : bus.im_req_wstrb;
    assign win_wdata = win_port ? bus.dm_req_wdata : bus.im_req_wdata;
    assign win_rd    = (win_wstrb == '0);

    // Byte offset and bits above the SRAM window are don't-care; addresses alias.
    assign unused_addr_bits = ^{win_addr[ADDR_W-1:SRAM_AW+ADDR_LSB], win_addr[ADDR_LSB-1:0]};

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_DM;
            port_q       <= PORT_IM;
            rd_q         <= 1'b0;
            cs_q         <= 1'b0;
            oe_q         <= 1'b0;
            web_q        <= '1;
            a_q          <= '0;
            di_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            rd_q         <= rd_d;
            cs_q         <= cs_d;
            oe_q         <= oe_d;
            web_q        <= web_d;
            a_q          <= a_d;
            di_q         <= di_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        rd_d         = rd_q;
        cs_d         = cs_q;
        oe_d         = oe_q;
        web_d        = web_q;
        a_d          = a_q;
        di_d         = di_q;

        case (state_q)
            IDLE, RESP: begin
                if (granted) begin
                    state_d      = CMD;
                    last_grant_d = win_port;
                    port_d       = win_port;
                    rd_d         = win_rd;
                    cs_d         = 1'b1;
                    oe_d         = win_rd;
                    web_d        = ~win_wstrb;
                    a_d          = win_addr[SRAM_AW+ADDR_LSB-1:ADDR_LSB];
                    di_d         = win_wdata;
                end else begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                end
            end
            CMD: begin
                // OE is held through RESP on reads so DO stays driven while it is returned.
                state_d = RESP;
                cs_d    = 1'b0;
                web_d   = '1;
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b0;
                oe_d    = 1'b0;
                web_d   = '1;
            end
        endcase
    end

    assign rsp_active = (state_q == RESP);

    assign bus.im_req_ready = gnt[PORT_IM];
    assign bus.dm_req_ready = gnt[PORT_DM];

    assign bus.im_rsp_valid = rsp_active && (port_q == PORT_IM);
    assign bus.dm_rsp_valid = rsp_active && (port_q == PORT_DM);
    assign bus.im_rsp_rdata = (bus.im_rsp_valid && rd_q) ? bus.DO : '0;
    assign bus.dm_rsp_rdata = (bus.dm_rsp_valid && rd_q) ? bus.DO : '0;

    assign bus.CS  = cs_q;
    assign bus.OE  = oe_q;
    assign bus.WEB = web_q;
    assign bus.A   = a_q;
    assign bus.DI  = di_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - Self-checking bench for sram_port_arbiter with a behavioural SRAM
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int SRAM_AW = 14;
    localparam int DATA_W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW), .DATA_W(DATA_W)) bus ();

    sram_port_arbiter #(.ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW), .DATA_W(DATA_W)) dut (
        .CK  (clk),
        .RST (rst),
        .bus (bus)
    );

    // Behavioural synchronous SRAM: 64 words, write and read captured on the rising edge.
    logic [31:0] sram    [64];
    logic [31:0] ref_mem [64];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    always @(posedge clk) begin
        if (pl_en) begin
            sram[pl_idx] <= pl_val;
        end else if (bus.CS) begin
            for (int b = 0; b < 4; b++)
                if (!bus.WEB[b]) sram[bus.A[5:0]][b*8 +: 8] <= bus.DI[b*8 +: 8];
            if (bus.OE) bus.DO <= sram[bus.A[5:0]];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        if (p == 0) begin
            bus.im_req_valid = v; bus.im_req_addr = a; bus.im_req_wstrb = s; bus.im_req_wdata = d;
        end else begin
            bus.dm_req_valid = v; bus.dm_req_addr = a; bus.dm_req_wstrb = s; bus.dm_req_wdata = d;
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = 6'(idx); pl_val = val; ref_mem[idx] = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic fill_mem(input logic [31:0] seed);
        for (int i = 0; i < 64; i++) preload(i, seed ^ (32'(i) * 32'h0103_0507));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        im_v;
        logic [31:0] im_addr;
        logic [3:0]  im_wstrb;
        logic [31:0] im_wdata;
        logic        dm_v;
        logic [31:0] dm_addr;
        logic [3:0]  dm_wstrb;
        logic [31:0] dm_wdata;
        logic [1:0]  exp_ready;   // {dm, im}
        logic [13:0] exp_a;
        logic [3:0]  exp_web;
        logic        exp_oe;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input int n, input vec_t v);
        logic dm_win;
        dm_win = v.exp_ready[1];
        @(posedge clk); #1;
        drive(0, v.im_v, v.im_addr, v.im_wstrb, v.im_wdata);
        drive(1, v.dm_v, v.dm_addr, v.dm_wstrb, v.dm_wdata);
        @(negedge clk);
        chk($sformatf("vec%0d_im_ready", n), bus.im_req_ready, v.exp_ready[0]);
        chk($sformatf("vec%0d_dm_ready", n), bus.dm_req_ready, v.exp_ready[1]);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk($sformatf("vec%0d_cmd_cs", n), bus.CS, 1'b1);
        chk($sformatf("vec%0d_cmd_a", n), bus.A, v.exp_a);
        chk($sformatf("vec%0d_cmd_web", n), bus.WEB, v.exp_web);
        chk($sformatf("vec%0d_cmd_oe", n), bus.OE, v.exp_oe);
        @(negedge clk);
        chk($sformatf("vec%0d_rsp_cs", n), bus.CS, 1'b0);
        chk($sformatf("vec%0d_rsp_web", n), bus.WEB, 4'hF);
        chk($sformatf("vec%0d_win_valid", n), dm_win ? bus.dm_rsp_valid : bus.im_rsp_valid, 1'b1);
        chk($sformatf("vec%0d_win_rdata", n), dm_win ? bus.dm_rsp_rdata : bus.im_rsp_rdata, v.exp_rdata);
        chk($sformatf("vec%0d_lose_valid", n), dm_win ? bus.im_rsp_valid : bus.dm_rsp_valid, 1'b0);
        chk($sformatf("vec%0d_lose_rdata", n), dm_win ? bus.im_rsp_rdata : bus.dm_rsp_rdata, 32'h0);
    endtask

    // Random-phase model state: pending requests and the last two cycles' grants.
    logic        pend    [2];
    logic [31:0] r_addr  [2];
    logic [3:0]  r_wstrb [2];
    logic [31:0] r_wdata [2];

    initial begin
        logic        gv, gp, model_last, exp_v, exp_p;
        logic        g1_v, g1_p, g1_rd, g2_v, g2_p, g2_rd;
        logic [13:0] g1_a;
        logic [3:0]  g1_web;
        logic [31:0] g1_di, g1_rdata, g2_rdata;
        logic [5:0]  idx;

        pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        drive(0, 1'b1, 32'h40, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h80, 4'h0, 32'h0);

        vecs[0] = '{1'b1, 32'h0000_0040, 4'h0, 32'h0,         1'b0, 32'h0,         4'h0, 32'h0,         2'b01, 14'h10, 4'hF, 1'b1, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 32'h0,         4'h0, 32'h0,         1'b1, 32'h0000_0080, 4'h2, 32'h0000_AB00, 2'b10, 14'h20, 4'hD, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0,         4'h0, 32'h0,         1'b1, 32'h0000_0080, 4'h0, 32'h0,         2'b10, 14'h20, 4'hF, 1'b1, 32'h1122_AB44};
        vecs[3] = '{1'b1, 32'h0001_0004, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0,         4'h0, 32'h0,         2'b01, 14'h01, 4'h0, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 32'h0,         4'h0, 32'h0,         1'b1, 32'h0000_0004, 4'h0, 32'h0,         2'b10, 14'h01, 4'hF, 1'b1, 32'hCAFE_F00D};
        vecs[5] = '{1'b1, 32'h0000_0007, 4'h0, 32'h0,         1'b0, 32'h0,         4'h0, 32'h0,         2'b01, 14'h01, 4'hF, 1'b1, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 32'h0,         4'h0, 32'h0,         1'b1, 32'hFFFF_0043, 4'h9, 32'hAA00_00BB, 2'b10, 14'h10, 4'h6, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 32'h0000_0040, 4'h0, 32'h0,         1'b0, 32'h0,         4'h0, 32'h0,         2'b01, 14'h10, 4'hF, 1'b1, 32'hAAAD_BEBB};

        // Reset state, with both requests held valid during reset.
        @(posedge clk); #1;
        fill_mem(32'h5A5A_0000);
        preload(16'h10, 32'hDEAD_BEEF);
        preload(16'h20, 32'h1122_3344);
        @(negedge clk);
        chk("rst_cs", bus.CS, 1'b0);
        chk("rst_oe", bus.OE, 1'b0);
        chk("rst_web", bus.WEB, 4'hF);
        chk("rst_a", bus.A, 14'h0);
        chk("rst_di", bus.DI, 32'h0);
        chk("rst_im_ready", bus.im_req_ready, 1'b0);
        chk("rst_dm_ready", bus.dm_req_ready, 1'b0);
        chk("rst_im_rsp", {bus.im_rsp_valid, bus.im_rsp_rdata}, 33'h0);
        chk("rst_dm_rsp", {bus.dm_rsp_valid, bus.dm_rsp_rdata}, 33'h0);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Collision fairness from reset: both ports valid every cycle.
        fill_mem(32'h3C3C_0000);
        do_reset();
        drive(0, 1'b1, 32'h40, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h80, 4'h0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_v = (k % 2 == 0);
            exp_p = ((k / 2) % 2 == 1);
            chk($sformatf("tie%0d_im_ready", k), bus.im_req_ready, exp_v && !exp_p);
            chk($sformatf("tie%0d_dm_ready", k), bus.dm_req_ready, exp_v && exp_p);
            if (k >= 2 && exp_v) begin
                exp_p = (((k - 2) / 2) % 2 == 1);
                chk($sformatf("tie%0d_im_rsp", k), bus.im_rsp_valid, !exp_p);
                chk($sformatf("tie%0d_dm_rsp", k), bus.dm_rsp_valid, exp_p);
                chk($sformatf("tie%0d_rdata", k), exp_p ? bus.dm_rsp_rdata : bus.im_rsp_rdata,
                    exp_p ? ref_mem[16'h20] : ref_mem[16'h10]);
            end else begin
                chk($sformatf("tie%0d_no_rsp", k), {bus.im_rsp_valid, bus.dm_rsp_valid}, 2'b00);
            end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);

        // Back-to-back: DM re-requests in its own RESP cycle.
        #1 drive(1, 1'b1, 32'h8, 4'h0, 32'h0);
        @(negedge clk); chk("b2b_t0_ready", bus.dm_req_ready, 1'b1);
        @(posedge clk); #1 drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); chk("b2b_t1_cs", bus.CS, 1'b1); chk("b2b_t1_a", bus.A, 14'h2);
        @(posedge clk); #1 drive(1, 1'b1, 32'hC, 4'h0, 32'h0);
        @(negedge clk);
        chk("b2b_t2_rsp", bus.dm_rsp_valid, 1'b1);
        chk("b2b_t2_rdata", bus.dm_rsp_rdata, ref_mem[2]);
        chk("b2b_t2_ready", bus.dm_req_ready, 1'b1);
        chk("b2b_t2_cs", bus.CS, 1'b0);
        @(posedge clk); #1 drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); chk("b2b_t3_cs", bus.CS, 1'b1); chk("b2b_t3_a", bus.A, 14'h3);
        @(negedge clk);
        chk("b2b_t4_rsp", bus.dm_rsp_valid, 1'b1);
        chk("b2b_t4_rdata", bus.dm_rsp_rdata, ref_mem[3]);
        repeat (2) @(posedge clk);

        // Reset asserted in the middle of a CMD cycle.
        #1 drive(0, 1'b1, 32'h40, 4'h0, 32'h0);
        @(negedge clk); chk("mid_ready", bus.im_req_ready, 1'b1);
        @(posedge clk); #1 drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); chk("mid_cmd_cs", bus.CS, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_async_cs", bus.CS, 1'b0);
        chk("mid_async_web", bus.WEB, 4'hF);
        chk("mid_async_oe", bus.OE, 1'b0);
        chk("mid_async_rsp", {bus.im_rsp_valid, bus.dm_rsp_valid}, 2'b00);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mid_post%0d_rsp", k), {bus.im_rsp_valid, bus.dm_rsp_valid, bus.CS}, 3'b000);
        end
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h40, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h80, 4'h0, 32'h0);
        @(negedge clk);
        chk("mid_tie_im", bus.im_req_ready, 1'b1);
        chk("mid_tie_dm", bus.dm_req_ready, 1'b0);
        @(posedge clk); #1 drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); chk("mid_wait_dm", bus.dm_req_ready, 1'b0);
        @(negedge clk); chk("mid_late_dm", bus.dm_req_ready, 1'b1);
        @(posedge clk); #1 drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);

        // Randomized traffic against a transaction-level model.
        do_reset();
        model_last = PORT_DM;
        g1_v = 1'b0; g2_v = 1'b0; g1_p = 1'b0; g2_p = 1'b0; g1_rd = 1'b0; g2_rd = 1'b0;
        g1_a = '0; g1_web = '1; g1_di = '0; g1_rdata = '0; g2_rdata = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 99) < 55) begin
                    pend[p]    = 1'b1;
                    r_addr[p]  = {16'($urandom), 8'h00, 6'($urandom_range(0, 63)), 2'($urandom)};
                    r_wstrb[p] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                    r_wdata[p] = $urandom;
                end
                drive(p, pend[p], r_addr[p], r_wstrb[p], r_wdata[p]);
            end
            @(negedge clk);
            // A grant is possible in any cycle not directly following a grant.
            gv = !g1_v && (pend[0] || pend[1]);
            gp = (pend[0] && pend[1]) ? ~model_last : pend[1];
            chk($sformatf("rnd%0d_im_ready", c), bus.im_req_ready, gv && gp == PORT_IM);
            chk($sformatf("rnd%0d_dm_ready", c), bus.dm_req_ready, gv && gp == PORT_DM);
            chk($sformatf("rnd%0d_cs", c), bus.CS, g1_v);
            if (g1_v) begin
                chk($sformatf("rnd%0d_a", c), bus.A, g1_a);
                chk($sformatf("rnd%0d_web", c), bus.WEB, g1_web);
                chk($sformatf("rnd%0d_oe", c), bus.OE, g1_rd);
                if (!g1_rd) chk($sformatf("rnd%0d_di", c), bus.DI, g1_di);
            end
            exp_v = g2_v && g2_p == PORT_IM;
            chk($sformatf("rnd%0d_im_rsp", c), bus.im_rsp_valid, exp_v);
            chk($sformatf("rnd%0d_im_rdata", c), bus.im_rsp_rdata, (exp_v && g2_rd) ? g2_rdata : 32'h0);
            exp_v = g2_v && g2_p == PORT_DM;
            chk($sformatf("rnd%0d_dm_rsp", c), bus.dm_rsp_valid, exp_v);
            chk($sformatf("rnd%0d_dm_rdata", c), bus.dm_rsp_rdata, (exp_v && g2_rd) ? g2_rdata : 32'h0);

            g2_v = g1_v; g2_p = g1_p; g2_rd = g1_rd; g2_rdata = g1_rdata;
            g1_v = gv;
            if (gv) begin
                g1_p     = gp;
                g1_a     = r_addr[gp][15:2];
                g1_rd    = (r_wstrb[gp] == 4'h0);
                g1_web   = ~r_wstrb[gp];
                g1_di    = r_wdata[gp];
                idx      = r_addr[gp][7:2];
                g1_rdata = g1_rd ? ref_mem[idx] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (r_wstrb[gp][b]) ref_mem[idx][b*8 +: 8] = r_wdata[gp][b*8 +: 8];
                model_last = gp;
                pend[gp]   = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish required finish");
        $fatal(1, "simulation time limit");
    end

endmodule
